// File: rtl/cmos_test_pkg.sv
// Shared types and truth tables for the CMOS gate cell self-test sequencer.
package cmos_test_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Load / count-down / expire timer spacing vector application from sampling.
module settle_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  // Expires on the last counting cycle so the wait spans exactly CYCLES clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYCLES);
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire_c = (cnt == W'(1));

endmodule

// File: rtl/cmos_gate_tester.sv
// Walks every input vector through a gate-under-test, samples after a settle
// time and counts mismatches against an expected truth table.
module cmos_gate_tester
  import cmos_test_pkg::*;
#(
  parameter int unsigned             N_IN          = 2,
  parameter int unsigned             SETTLE_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0]    EXP_TABLE     = 4'b1110
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int unsigned CW = N_IN + 1;
  localparam logic [CW-1:0] ERR_MAX  = CW'(1 << N_IN);
  localparam logic [CW-1:0] VEC_LAST = CW'((1 << N_IN) - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   vec;
  logic            settle_done_c;
  logic            mismatch_c;
  logic            last_c;

  // Case-inequality so a floating or unknown GUT output is flagged
  assign mismatch_c = (dut_out !== EXP_TABLE[vec[N_IN-1:0]]);
  assign last_c     = (vec == VEC_LAST);

  generate
    if (SETTLE_CYCLES > 0) begin : g_timer
      settle_timer #(.CYCLES(SETTLE_CYCLES)) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == APPLY),
        .en       (state == SETTLE),
        .expire_c (settle_done_c)
      );
    end else begin : g_no_timer
      assign settle_done_c = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = APPLY;
      APPLY:   state_nxt = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      SETTLE:  if (settle_done_c) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last_c ? DONE : APPLY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec        <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done       <= 1'b0;
      fail_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec       <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            busy      <= 1'b1;
          end
        end
        APPLY: dut_in <= vec[N_IN-1:0];
        SAMPLE: begin
          if (mismatch_c) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec[N_IN-1:0];
            if (err_count != ERR_MAX) err_count <= err_count + CW'(1);
          end
          if (!last_c) vec <= vec + CW'(1);
        end
        DONE: begin
          done <= 1'b1;
          pass <= (err_count == '0);
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_gate_tester.sv
// Directed self-checking bench for cmos_gate_tester (OR2 and OR3 configurations).
module tb_cmos_gate_tester;
  import cmos_test_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] dut_in_a;
  logic       dut_out_a;
  logic       busy_a, done_a, pass_a, fail_valid_a;
  logic [2:0] err_count_a;
  logic [1:0] fail_vec_a;
  logic [2:0] dut_in_b;
  logic       dut_out_b;
  logic       busy_b, done_b, pass_b, fail_valid_b;
  logic [3:0] err_count_b;
  logic [2:0] fail_vec_b;

  int checks = 0;
  int errors = 0;
  int mode = 0;          // 0 OR2, 1 NOR2, 2 stuck-0, 3 stuck-1
  int fails_seen = 0;
  int dones_seen = 0;
  logic [15:0] walk = '0;
  logic [1:0]  prev_in = '0;
  int cyc;
  logic busy1, pass1;

  always #5 clk = ~clk;

  cmos_gate_tester #(.N_IN(2), .SETTLE_CYCLES(2), .EXP_TABLE(TT_OR2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_count_a),
    .fail_valid(fail_valid_a), .fail_vec(fail_vec_a)
  );

  cmos_gate_tester #(.N_IN(3), .SETTLE_CYCLES(0), .EXP_TABLE(8'hFE)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
    .fail_valid(fail_valid_b), .fail_vec(fail_vec_b)
  );

  always_comb begin
    case (mode)
      0:       dut_out_a = |dut_in_a;
      1:       dut_out_a = ~|dut_in_a;
      2:       dut_out_a = 1'b0;
      default: dut_out_a = 1'b1;
    endcase
  end
  assign dut_out_b = |dut_in_b;

  always @(negedge clk) begin
    if (fail_valid_a) fails_seen++;
    if (done_a) dones_seen++;
    if (dut_in_a != prev_in) begin
      walk = {walk[11:0], 2'b00, dut_in_a};
      prev_in = dut_in_a;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input int inject_at, output int cycles, output logic b1, output logic p1);
    walk = '0; fails_seen = 0; dones_seen = 0; b1 = 1'b0; p1 = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cycles = 0;
    while (!done_a && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 1) begin b1 = busy_a; p1 = pass_a; end
      start_a = (cycles == inject_at);
    end
    start_a = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dut_in", 32'(dut_in_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_err", 32'(err_count_a), 32'd0);
    chk("rst_fail", 32'({fail_valid_a, fail_vec_a}), 32'd0);
    @(negedge clk) rst = 1'b0;

    // OR2 cell against OR2 table
    mode = 0;
    run_a(-1, cyc, busy1, pass1);
    chk("or2_latency", 32'(cyc), 32'd17);
    chk("or2_busy_early", 32'(busy1), 32'd1);
    chk("or2_pass", 32'(pass_a), 32'd1);
    chk("or2_err", 32'(err_count_a), 32'd0);
    chk("or2_busy_at_done", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    chk("or2_walk", 32'(walk), 32'h0123);
    chk("or2_no_fail", 32'(fails_seen), 32'd0);
    chk("or2_dut_in_hold", 32'(dut_in_a), 32'd3);
    chk("or2_pass_hold", 32'(pass_a), 32'd1);

    // NOR2 cell against OR2 table
    mode = 1;
    run_a(-1, cyc, busy1, pass1);
    chk("nor2_pass_cleared", 32'(pass1), 32'd0);
    chk("nor2_latency", 32'(cyc), 32'd17);
    chk("nor2_err", 32'(err_count_a), 32'd4);
    chk("nor2_fail_vec", 32'(fail_vec_a), 32'd3);
    chk("nor2_pass", 32'(pass_a), 32'd0);
    repeat (2) @(negedge clk);
    chk("nor2_fail_pulses", 32'(fails_seen), 32'd4);
    chk("nor2_walk", 32'(walk), 32'h0123);

    // Stuck-at-0 output
    mode = 2;
    run_a(-1, cyc, busy1, pass1);
    chk("sa0_err", 32'(err_count_a), 32'd3);
    chk("sa0_fail_vec", 32'(fail_vec_a), 32'd3);
    chk("sa0_pass", 32'(pass_a), 32'd0);

    // Stuck-at-1 output: only vector 0 disagrees
    mode = 3;
    run_a(-1, cyc, busy1, pass1);
    chk("sa1_err", 32'(err_count_a), 32'd1);
    chk("sa1_fail_vec", 32'(fail_vec_a), 32'd0);
    chk("sa1_pass", 32'(pass_a), 32'd0);
    repeat (2) @(negedge clk);
    chk("sa1_fail_pulses", 32'(fails_seen), 32'd1);

    // Start pulsed again mid-run (vector 1) is ignored
    mode = 0;
    run_a(6, cyc, busy1, pass1);
    chk("restart_latency", 32'(cyc), 32'd17);
    chk("restart_pass", 32'(pass_a), 32'd1);
    repeat (25) @(negedge clk);
    chk("restart_one_done", 32'(dones_seen), 32'd1);
    chk("restart_idle", 32'(busy_a), 32'd0);

    // Reset during SETTLE of vector 2
    dones_seen = 0;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_vec2", 32'(dut_in_a), 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_dut_in", 32'(dut_in_a), 32'd0);
    chk("rst_mid_busy", 32'(busy_a), 32'd0);
    chk("rst_mid_err", 32'(err_count_a), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("rst_mid_no_done", 32'(dones_seen), 32'd0);
    chk("rst_mid_pass", 32'(pass_a), 32'd0);
    run_a(-1, cyc, busy1, pass1);
    chk("post_rst_latency", 32'(cyc), 32'd17);
    chk("post_rst_pass", 32'(pass_a), 32'd1);

    // OR3 configuration with zero settle time
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    cyc = 0;
    while (!done_b && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("or3_latency", 32'(cyc), 32'd17);
    chk("or3_pass", 32'(pass_b), 32'd1);
    chk("or3_err", 32'(err_count_b), 32'd0);
    chk("or3_dut_in", 32'(dut_in_b), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
